// File: rtl/reg_pkg.sv
// rtl/reg_pkg.sv - shared constants and helpers for the reg_pipe pipeline register
//
// Contents:
//   REG_DEPTH_MAX : largest supported stage count
//   cnt_width()   : width of the occupied-stage counter for a given depth

package reg_pkg;

    localparam int REG_DEPTH_MAX = 16;

    // The counter must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// rtl/reg_pipe_stage.sv - one data/valid stage of the reg_pipe pipeline
//
// Parameters:
//   DATA_WIDTH : data width in bits
//   INIT_VAL   : data register value on reset
// Ports:
//   C        : clock, rising edge
//   R        : asynchronous active-low reset
//   din      : upstream data
//   vin      : upstream valid
//   rdy_down : downstream stage (or consumer) ready
//   fl       : synchronous flush, clears valid and leaves data untouched
//   dout     : registered stage data
//   vout     : registered stage valid
//   rdy_up   : this stage can accept a word on the next edge

module reg_pipe_stage #(
    parameter int                    DATA_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                  C,
    input  logic                  R,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  vin,
    input  logic                  rdy_down,
    input  logic                  fl,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  vout,
    output logic                  rdy_up
);

    // An empty stage always accepts; a full one accepts only if its word
    // moves on in the same edge.
    assign rdy_up = ~vout | rdy_down;

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            vout <= 1'b0;
            dout <= INIT_VAL;
        end else begin
            if (fl) begin
                vout <= 1'b0;
            end else if (rdy_up) begin
                vout <= vin;
            end
            // Data only moves with a real word, so bubbles leave the old
            // value in place and save toggles.
            if (rdy_up && vin && !fl) begin
                dout <= din;
            end
        end
    end

endmodule

// File: rtl/reg_pipe.sv
// rtl/reg_pipe.sv - multi-stage valid/ready pipeline register with bubble collapsing and flush
//
// Optional feature macro: REG_PIPE_CNT_EN (adds the CNT occupancy counter port)
//
// Parameters:
//   DATA_WIDTH : width of D and Q
//   DEPTH      : number of register stages, 1..REG_DEPTH_MAX
//   INIT_VAL   : reset value of every data register
// Ports:
//   C   : clock, rising edge
//   R   : asynchronous active-low reset
//   D   : input data
//   DV  : input valid
//   DR  : input ready (combinational from QR, FL and stage valids)
//   FL  : synchronous flush
//   Q   : last-stage data (registered)
//   QV  : last-stage valid (registered)
//   QR  : output ready
//   CNT : number of occupied stages (REG_PIPE_CNT_EN only)

module reg_pipe
    import reg_pkg::*;
#(
    parameter int                    DATA_WIDTH = 4,
    parameter int                    DEPTH      = 3,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                        C,
    input  logic                        R,
    input  logic [DATA_WIDTH-1:0]       D,
    input  logic                        DV,
    output logic                        DR,
    input  logic                        FL,
    output logic [DATA_WIDTH-1:0]       Q,
    output logic                        QV,
    input  logic                        QR
`ifdef REG_PIPE_CNT_EN
    ,
    output logic [cnt_width(DEPTH)-1:0] CNT
`endif
);

    if (DEPTH < 1 || DEPTH > REG_DEPTH_MAX) begin : g_bad_depth
        $error("reg_pipe: DEPTH out of range");
    end

    logic [DATA_WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0]      v;

    // Each stage keeps its own ready net so the combinational ready chain
    // is a sequence of distinct signals rather than one self-referencing bus.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic                  rdy_up;
        logic                  rdy_down;
        logic [DATA_WIDTH-1:0] din;
        logic                  vin;

        if (i == 0) begin : g_head
            assign din = D;
            assign vin = DV;
        end else begin : g_body
            assign din = d[i-1];
            assign vin = v[i-1];
        end

        if (i == DEPTH - 1) begin : g_tail
            assign rdy_down = QR;
        end else begin : g_link
            assign rdy_down = g_stage[i+1].rdy_up;
        end

        reg_pipe_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .INIT_VAL   (INIT_VAL)
        ) u_stage (
            .C        (C),
            .R        (R),
            .din      (din),
            .vin      (vin),
            .rdy_down (rdy_down),
            .fl       (FL),
            .dout     (d[i]),
            .vout     (v[i]),
            .rdy_up   (rdy_up)
        );
    end

    // Stage 0 also masks its incoming valid with FL internally, so blocking
    // DR during flush keeps the producer from believing a word was taken.
    assign DR = g_stage[0].rdy_up & ~FL;
    assign Q  = d[DEPTH-1];
    assign QV = v[DEPTH-1];

`ifdef REG_PIPE_CNT_EN
    localparam int CW = cnt_width(DEPTH);

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = DV & DR;
    assign out_xfer = QV & QR;

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            CNT <= '0;
        end else if (FL) begin
            CNT <= '0;
        end else if (in_xfer && !out_xfer) begin
            CNT <= CNT + CW'(1);
        end else if (out_xfer && !in_xfer) begin
            CNT <= CNT - CW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_reg_pipe.sv
// tb/tb_reg_pipe.sv - scoreboard-based self-checking bench for reg_pipe

module tb_reg_pipe;

    localparam int DW = 4;
    localparam int DP = 3;

    logic          C;
    logic          R;
    logic [DW-1:0] D;
    logic          DV;
    logic          DR;
    logic          FL;
    logic [DW-1:0] Q;
    logic          QV;
    logic          QR;
`ifdef REG_PIPE_CNT_EN
    logic [1:0]    CNT;
`endif

    int nvec = 0;
    int nerr = 0;
    logic [DW-1:0] sb [$];

    reg_pipe #(
        .DATA_WIDTH (DW),
        .DEPTH      (DP),
        .INIT_VAL   (4'd0)
    ) dut (
        .C   (C),
        .R   (R),
        .D   (D),
        .DV  (DV),
        .DR  (DR),
        .FL  (FL),
        .Q   (Q),
        .QV  (QV),
        .QR  (QR)
`ifdef REG_PIPE_CNT_EN
        ,
        .CNT (CNT)
`endif
    );

    initial C = 1'b0;
    always #5 C = ~C;

    // Scoreboard: words are pushed when an input handshake is seen and
    // popped and compared when an output handshake is seen.
    always @(negedge C) begin
        logic [DW-1:0] exp_w;
        if (R) begin
            if (QV && QR) begin
                nvec++;
                if (sb.size() == 0) begin
                    nerr++;
                    $display("FAIL sb_underflow: Q=%0d delivered, none expected", Q);
                end else begin
                    exp_w = sb.pop_front();
                    if (Q !== exp_w) begin
                        nerr++;
                        $display("FAIL sb_data: Q=%0d expected %0d", Q, exp_w);
                    end
                end
            end
            if (DV && DR) sb.push_back(D);
        end
    end

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic test_reset();
        R = 1'b0; D = '0; DV = 1'b0; FL = 1'b0; QR = 1'b0;
        #2;
        nvec++;
        if (QV !== 1'b0 || Q !== 4'd0 || DR !== 1'b1) begin
            nerr++;
            $display("FAIL reset_out: QV=%b Q=%0d DR=%b expected 0 0 1", QV, Q, DR);
        end
`ifdef REG_PIPE_CNT_EN
        nvec++;
        if (CNT !== 2'd0) begin
            nerr++;
            $display("FAIL reset_cnt: CNT=%0d expected 0", CNT);
        end
`endif
        tick();
        R = 1'b1;
        tick();
    endtask

    task automatic test_streaming();
        QR = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            DV = (n <= 6);
            D  = DW'(n);
            nvec++;
            if (DR !== 1'b1) begin
                nerr++;
                $display("FAIL stream_dr: cycle %0d DR=%b expected 1", n, DR);
            end
            tick();
            nvec++;
            if (QV !== (n >= 3 && n <= 8)) begin
                nerr++;
                $display("FAIL stream_qv: edge %0d QV=%b expected %b", n, QV, (n >= 3 && n <= 8));
            end
            if (n >= 3 && n <= 8) begin
                nvec++;
                if (Q !== DW'(n - 2)) begin
                    nerr++;
                    $display("FAIL stream_q: edge %0d Q=%0d expected %0d", n, Q, n - 2);
                end
            end
        end
        DV = 1'b0;
    endtask

    task automatic test_backpressure();
        QR = 1'b0;
        for (int k = 5; k <= 7; k++) begin
            D = DW'(k); DV = 1'b1;
            nvec++;
            if (DR !== 1'b1) begin
                nerr++;
                $display("FAIL bp_accept: D=%0d DR=%b expected 1", k, DR);
            end
            tick();
        end
        D = 4'd8;
        nvec++;
        if (DR !== 1'b0) begin
            nerr++;
            $display("FAIL bp_full_dr: DR=%b expected 0", DR);
        end
`ifdef REG_PIPE_CNT_EN
        nvec++;
        if (CNT !== 2'd3) begin
            nerr++;
            $display("FAIL bp_full_cnt: CNT=%0d expected 3", CNT);
        end
`endif
        QR = 1'b1;
        #1;
        nvec++;
        if (DR !== 1'b1 || QV !== 1'b1 || Q !== 4'd5) begin
            nerr++;
            $display("FAIL bp_release: DR=%b QV=%b Q=%0d expected 1 1 5", DR, QV, Q);
        end
        tick();
        DV = 1'b0;
        nvec++;
        if (Q !== 4'd6) begin
            nerr++;
            $display("FAIL bp_next: Q=%0d expected 6", Q);
        end
`ifdef REG_PIPE_CNT_EN
        nvec++;
        if (CNT !== 2'd3) begin
            nerr++;
            $display("FAIL bp_swap_cnt: CNT=%0d expected 3", CNT);
        end
`endif
        repeat (3) tick();
        nvec++;
        if (QV !== 1'b0) begin
            nerr++;
            $display("FAIL bp_drain: QV=%b expected 0", QV);
        end
    endtask

    task automatic test_bubble();
        QR = 1'b0;
        D = 4'd9;  DV = 1'b1; tick();
        DV = 1'b0;            tick();
        D = 4'd10; DV = 1'b1; tick();
        DV = 1'b0;
        repeat (2) tick();
        nvec++;
        if (QV !== 1'b1 || Q !== 4'd9 || DR !== 1'b1) begin
            nerr++;
            $display("FAIL bubble_hold: QV=%b Q=%0d DR=%b expected 1 9 1", QV, Q, DR);
        end
`ifdef REG_PIPE_CNT_EN
        nvec++;
        if (CNT !== 2'd2) begin
            nerr++;
            $display("FAIL bubble_cnt: CNT=%0d expected 2", CNT);
        end
`endif
        QR = 1'b1;
        tick();
        nvec++;
        if (QV !== 1'b1 || Q !== 4'd10) begin
            nerr++;
            $display("FAIL bubble_adjacent: QV=%b Q=%0d expected 1 10", QV, Q);
        end
        tick();
        nvec++;
        if (QV !== 1'b0) begin
            nerr++;
            $display("FAIL bubble_empty: QV=%b expected 0", QV);
        end
    endtask

    task automatic test_flush();
        QR = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            D = DW'(k); DV = 1'b1; tick();
        end
        QR = 1'b1; FL = 1'b1; D = 4'd4;
        #1;
        nvec++;
        if (DR !== 1'b0 || QV !== 1'b1 || Q !== 4'd1) begin
            nerr++;
            $display("FAIL flush_cycle: DR=%b QV=%b Q=%0d expected 0 1 1", DR, QV, Q);
        end
        tick();
        FL = 1'b0; DV = 1'b0;
        // Words 2 and 3 were discarded by the flush.
        sb.delete();
        #1;
        nvec++;
        if (QV !== 1'b0 || DR !== 1'b1 || Q !== 4'd1) begin
            nerr++;
            $display("FAIL flush_after: QV=%b DR=%b Q=%0d expected 0 1 1", QV, DR, Q);
        end
`ifdef REG_PIPE_CNT_EN
        nvec++;
        if (CNT !== 2'd0) begin
            nerr++;
            $display("FAIL flush_cnt: CNT=%0d expected 0", CNT);
        end
`endif
        tick();
    endtask

    task automatic test_back_to_back();
        QR = 1'b0;
        for (int k = 11; k <= 13; k++) begin
            D = DW'(k); DV = 1'b1; tick();
        end
        QR = 1'b1;
        for (int k = 14; k <= 17; k++) begin
            D = DW'(k); DV = 1'b1;
            #1;
            nvec++;
            if (DR !== 1'b1 || QV !== 1'b1) begin
                nerr++;
                $display("FAIL b2b_hs: step %0d DR=%b QV=%b expected 1 1", k - 14, DR, QV);
            end
            tick();
`ifdef REG_PIPE_CNT_EN
            nvec++;
            if (CNT !== 2'd3) begin
                nerr++;
                $display("FAIL b2b_cnt: step %0d CNT=%0d expected 3", k - 14, CNT);
            end
`endif
        end
        DV = 1'b0;
        repeat (3) tick();
        nvec++;
        if (QV !== 1'b0 || sb.size() != 0) begin
            nerr++;
            $display("FAIL b2b_drain: QV=%b pending=%0d expected 0 0", QV, sb.size());
        end
    endtask

    task automatic test_reset_midstream();
        QR = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            D = DW'(k); DV = 1'b1; tick();
        end
        DV = 1'b0;
        @(posedge C);
        #3;
        R = 1'b0;
        #1;
        nvec++;
        if (QV !== 1'b0 || Q !== 4'd0 || DR !== 1'b1) begin
            nerr++;
            $display("FAIL rst_mid_out: QV=%b Q=%0d DR=%b expected 0 0 1", QV, Q, DR);
        end
`ifdef REG_PIPE_CNT_EN
        nvec++;
        if (CNT !== 2'd0) begin
            nerr++;
            $display("FAIL rst_mid_cnt: CNT=%0d expected 0", CNT);
        end
`endif
        sb.delete();
        tick();
        R = 1'b1; QR = 1'b1;
        repeat (3) tick();
        nvec++;
        if (QV !== 1'b0) begin
            nerr++;
            $display("FAIL rst_mid_after: QV=%b expected 0", QV);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubble();
        test_flush();
        test_back_to_back();
        test_reset_midstream();
        nvec++;
        if (sb.size() != 0) begin
            nerr++;
            $display("FAIL sb_leftover: pending=%0d expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/reg_pipe.md
# reg_pipe

Parametrised multi-stage pipeline register with a valid/ready handshake, per-stage bubble collapsing, and synchronous flush. It generalises the single register to DEPTH stages of DATA_WIDTH bits. Producer stalls propagate only as far as the first empty stage. It sits between any two handshaked datapath blocks that need timing-closure registers without losing throughput.

## Interface
- DATA_WIDTH, 4: width of D and Q in bits.
- DEPTH, 3: number of register stages; legal range 1..16.
- INIT_VAL, 0: value every data register takes on reset.
- C  input  1: clock; all state updates on its rising edge.
- R  input  1: reset; asynchronous, active-low.
- D  input  DATA_WIDTH: input data.
- DV  input  1: input valid.
- DR  output  1: input ready; a transfer occurs on a rising edge of C when DV=1 and DR=1.
- FL  input  1: synchronous flush.
- Q  output  DATA_WIDTH: data of the last stage.
- QV  output  1: output valid; equals the valid bit of the last stage.
- QR  input  1: output ready; a transfer occurs on a rising edge of C when QV=1 and QR=1.
- CNT  output  $clog2(DEPTH+1): occupied-stage count. Present only with REG_PIPE_CNT_EN.

## Operation
- Each stage i (0 = input side, DEPTH-1 = output side) holds data d[i] and valid v[i].
- Stage ready: rdy[DEPTH-1] = ~v[DEPTH-1] | QR; rdy[i] = ~v[i] | rdy[i+1]. The ready chain is combinational, so bubbles collapse.
- DR = rdy[0] & ~FL.
- When rdy[i]=1, stage i loads from its upstream source on the clock edge:
  - stage 0 loads d=D and v=DV & ~FL;
  - stage i>0 loads d=d[i-1] and v=v[i-1].
- When rdy[i]=0, stage i holds its data and valid.
- A data register loads only when its upstream valid is 1. Otherwise d[i] retains its old value; only v[i] updates.
- Q = d[DEPTH-1] and QV = v[DEPTH-1], both driven directly from registers.
- Flush: while FL=1, DR=0. At the edge, all v[i] clear to 0 and data registers are unchanged.
- An output transfer (QV=1, QR=1) in the flush cycle is still a valid handshake; the consumer keeps that word.
- Reset (R=0): all v[i]=0 and all d[i]=INIT_VAL immediately, independent of C. Outputs during reset: QV=0, Q=INIT_VAL, DR=1, CNT=0.
- Reset mid-stream discards all words in flight, with no partial transfer.
- Data is never reordered, duplicated, or dropped, except by flush or reset.

## Timing
- Latency from an input transfer to QV=1 for that word is DEPTH cycles when the pipe is empty and QR=1.
- With QR held 1, throughput is one word per cycle and DR stays 1.
- With QR=0, input transfers continue until all DEPTH stages are valid; DR drops in the cycle in which the pipe is full.
- Simultaneous full pipe, QR=1 and DV=1: both transfers occur in the same cycle and the occupancy is unchanged.
- DR depends combinationally on QR and FL; all other outputs are registered.
- R deassertion is expected synchronous to C; the first valid edge is the first rising edge of C with R=1.

## Configuration
- REG_PIPE_CNT_EN defined:
  - CNT port exists, driven by a registered up/down counter.
  - +1 on an input transfer without an output transfer; -1 on an output transfer without an input transfer; otherwise unchanged.
  - Flush or reset sets it to 0.
  - CNT always equals the number of set v[i].
- REG_PIPE_CNT_EN undefined: no CNT port and no counter logic; all other behaviour is identical.

## Structure
- Shared package reg_pkg holds the DEPTH limit constant (16) and the count-width function $clog2(DEPTH+1) used for CNT.
- Sub-module reg_pipe_stage implements one stage: ports C, R, din, vin, rdy_down, dout, vout, rdy_up, and fl, plus parameters DATA_WIDTH and INIT_VAL.
- reg_pipe instantiates reg_pipe_stage DEPTH times in a generate loop and adds the optional counter.

## Test plan
All scenarios use DATA_WIDTH=4, DEPTH=3, INIT_VAL=0, and REG_PIPE_CNT_EN defined.
- Reset: assert R=0 mid-clock with stages full → QV=0, Q=0, CNT=0, DR=1 immediately, without waiting for a C edge.
- Streaming: QR=1, D=1,2,3,… on consecutive cycles with DV=1 → Q=1 with QV=1 three cycles after the first transfer, then 2,3,… every cycle; DR stays 1.
- Backpressure: QR=0, push 5,6,7,8 → 5,6,7 accepted, DR=0 on the fourth offer, CNT=3. Then QR=1 for one cycle → Q=5 consumed, 8 accepted in the same cycle, CNT stays 3.
- Bubble collapse: push 9, idle one cycle, push 10, hold QR=0 → both words settle in adjacent stages with no gap, CNT=2; raising QR yields 9 then 10 on consecutive cycles.
- Flush: pipe holds 1,2,3 with QR=1 and FL=1 for one cycle → 1 transfers out in that cycle; afterwards QV=0 and CNT=0, and DR=0 during the flush cycle.
- Simultaneous events: pipe full, DV=1 and QR=1 for four cycles → four input and four output transfers, order preserved, CNT constant at 3.
